// File: rtl/svc_soc_io_arb.sv
// Two-requester round-robin arbiter onto a simple I/O port.
// Writes issue at one per cycle; a read holds the port for one return cycle.
module svc_soc_io_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_valid,
    output logic            m0_ready,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_valid,
    output logic            m1_ready,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            io_ren,
    output logic [AW-1:0]   io_raddr,
    input  logic [DW-1:0]   io_rdata,
    output logic            io_wen,
    output logic [AW-1:0]   io_waddr,
    output logic [DW-1:0]   io_wdata,
    output logic [DW/8-1:0] io_wstrb
);

    typedef enum logic {IDLE, RD_WAIT} state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   owner_q, owner_d;
    logic   gnt0, gnt1, acc, sel, sel_we;

    // Grants are gated by rst_n so nothing leaks out combinationally during reset.
    always_comb begin
        gnt0   = rst_n && (state_q == IDLE) && m0_valid && (!m1_valid || last_grant_q);
        gnt1   = rst_n && (state_q == IDLE) && m1_valid && (!m0_valid || !last_grant_q);
        acc    = gnt0 | gnt1;
        sel    = gnt1;
        sel_we = sel ? m1_we : m0_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        case (state_q)
            IDLE: begin
                if (acc) last_grant_d = sel;
                if (acc && !sel_we) begin
                    state_d = RD_WAIT;
                    owner_d = sel;
                end
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_ready  = gnt0;
        m1_ready  = gnt1;
        io_wen    = 1'b0;
        io_waddr  = '0;
        io_wdata  = '0;
        io_wstrb  = '0;
        io_ren    = 1'b0;
        io_raddr  = '0;
        m0_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rvalid = 1'b0;
        m1_rdata  = '0;
        if (acc && sel_we) begin
            io_wen   = 1'b1;
            io_waddr = sel ? m1_addr  : m0_addr;
            io_wdata = sel ? m1_wdata : m0_wdata;
            io_wstrb = sel ? m1_wstrb : m0_wstrb;
        end
        if (acc && !sel_we) begin
            io_ren   = 1'b1;
            io_raddr = sel ? m1_addr : m0_addr;
        end
        if (rst_n && (state_q == RD_WAIT)) begin
            if (owner_q) begin
                m1_rvalid = 1'b1;
                m1_rdata  = io_rdata;
            end else begin
                m0_rvalid = 1'b1;
                m0_rdata  = io_rdata;
            end
        end
    end

endmodule

// File: tb/tb_svc_soc_io_arb.sv
// Scoreboard bench for svc_soc_io_arb: stimulus queues expected port events,
// a negedge monitor matches every observed event against the queue.
module tb_svc_soc_io_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_valid, m0_ready, m0_we, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [SW-1:0] m0_wstrb;
    logic          m1_valid, m1_ready, m1_we, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [SW-1:0] m1_wstrb;
    logic          io_ren, io_wen;
    logic [AW-1:0] io_raddr, io_waddr;
    logic [DW-1:0] io_rdata, io_wdata;
    logic [SW-1:0] io_wstrb;

    svc_soc_io_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata),
        .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 write, 1 read issue, 2 read return; sel = {m1_rvalid,m0_rvalid,m1_ready,m0_ready}
    typedef struct packed {
        logic [1:0]    kind;
        logic [3:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } ev_t;

    ev_t q[$];
    int  qcyc[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int p, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        ev_t e;
        e.kind = k[1:0];
        e.sel  = (k == 2) ? (4'b0100 << p) : (4'b0001 << p);
        e.addr = a;
        e.data = d;
        e.strb = s;
        q.push_back(e);
        qcyc.push_back(cyc);
    endtask

    ev_t  obs;
    logic obs_any;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                                  io_ren, io_wen, io_raddr, io_waddr, io_wdata, io_wstrb}, '0);
        end else begin
            chk("ren_wen_exclusive", {255'd0, io_ren & io_wen}, '0);
            chk("idle_zero", {io_raddr & {AW{~io_ren}}, io_waddr & {AW{~io_wen}},
                              io_wdata & {DW{~io_wen}}, io_wstrb & {SW{~io_wen}},
                              m0_rdata & {DW{~m0_rvalid}}, m1_rdata & {DW{~m1_rvalid}}}, '0);
            while (qcyc.size() > 0 && qcyc[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_event @cyc %0d: expected %0h at cyc %0d never seen", cyc, q[0], qcyc[0]);
                void'(q.pop_front());
                void'(qcyc.pop_front());
            end
            obs_any = io_wen | io_ren | m0_rvalid | m1_rvalid | m0_ready | m1_ready;
            if (obs_any) begin
                obs.kind = io_wen ? 2'd0 : (io_ren ? 2'd1 : 2'd2);
                obs.sel  = {m1_rvalid, m0_rvalid, m1_ready, m0_ready};
                obs.addr = io_wen ? io_waddr : io_raddr;
                obs.data = io_wen ? io_wdata : (m1_rvalid ? m1_rdata : m0_rdata);
                obs.strb = io_wstrb;
                if (qcyc.size() > 0 && qcyc[0] == cyc) begin
                    chk("event", obs, q[0]);
                    void'(q.pop_front());
                    void'(qcyc.pop_front());
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event @cyc %0d: got %0h expected none", cyc, obs);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        io_rdata = $urandom;
    endtask

    task automatic set_m0(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
        m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    endtask

    task automatic set_m1(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
        m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    endtask

    logic m_idle, m_lg, m_owner, g0, g1, p, pwe;

    initial begin
        rst_n    = 1'b0;
        io_rdata = '0;
        // Both requesters hold writes through reset; nothing may be granted until release.
        set_m0(1'b1, 1'b1, 32'h100, 32'hA0A0A0A0, 4'hF);
        set_m1(1'b1, 1'b1, 32'h200, 32'hB1B1B1B1, 4'h3);
        repeat (3) nxt();

        nxt(); rst_n = 1'b1; expect_ev(0, 0, 32'h100, 32'hA0A0A0A0, 4'hF);
        nxt();               expect_ev(0, 1, 32'h200, 32'hB1B1B1B1, 4'h3);
        nxt();               expect_ev(0, 0, 32'h100, 32'hA0A0A0A0, 4'hF);
        nxt();               expect_ev(0, 1, 32'h200, 32'hB1B1B1B1, 4'h3);

        nxt(); set_m1(1'b0, 1'b0, '0, '0, '0);
        set_m0(1'b1, 1'b1, 32'h10, 32'hA5, 4'h1); expect_ev(0, 0, 32'h10, 32'hA5, 4'h1);
        nxt(); set_m0(1'b0, 1'b0, '0, '0, '0);

        nxt(); set_m1(1'b1, 1'b0, 32'h20, '0, '0); expect_ev(1, 1, 32'h20, '0, '0);
        nxt(); set_m1(1'b0, 1'b0, '0, '0, '0);
        io_rdata = 32'hDEADBEEF; expect_ev(2, 1, '0, 32'hDEADBEEF, '0);

        // Write raised during the read-return cycle must wait one cycle.
        nxt(); set_m0(1'b1, 1'b0, 32'h30, '0, '0); expect_ev(1, 0, 32'h30, '0, '0);
        nxt(); set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b1, 1'b1, 32'h40, 32'h55, 4'h2);
        io_rdata = 32'h12345678; expect_ev(2, 0, '0, 32'h12345678, '0);
        nxt(); expect_ev(0, 1, 32'h40, 32'h55, 4'h2);
        nxt(); set_m1(1'b0, 1'b0, '0, '0, '0);

        // Reset mid read-return: no rvalid, outputs clear without a clock edge.
        set_m0(1'b1, 1'b0, 32'h50, '0, '0); expect_ev(1, 0, 32'h50, '0, '0);
        nxt(); set_m0(1'b0, 1'b0, '0, '0, '0);
        io_rdata = 32'hCAFEF00D;
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                                       io_ren, io_wen, io_raddr, io_waddr, io_wdata, io_wstrb}, '0);
        nxt();
        nxt(); rst_n = 1'b1;
        set_m1(1'b1, 1'b0, 32'h60, '0, '0); expect_ev(1, 1, 32'h60, '0, '0);
        nxt(); set_m1(1'b0, 1'b0, '0, '0, '0);
        io_rdata = 32'h0BADF00D; expect_ev(2, 1, '0, 32'h0BADF00D, '0);

        // Random two-requester traffic against a small arbitration model.
        m_idle = 1'b1; m_lg = 1'b1; m_owner = 1'b0;
        for (int i = 0; i < 300; i++) begin
            nxt();
            set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFF,
                   $urandom, 4'($urandom_range(0, 15)));
            set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFF,
                   $urandom, 4'($urandom_range(0, 15)));
            if (m_idle) begin
                g0 = m0_valid && (!m1_valid || m_lg);
                g1 = m1_valid && (!m0_valid || !m_lg);
                if (g0 || g1) begin
                    p   = g1;
                    pwe = p ? m1_we : m0_we;
                    m_lg = p;
                    if (pwe)
                        expect_ev(0, int'(p), p ? m1_addr : m0_addr,
                                  p ? m1_wdata : m0_wdata, p ? m1_wstrb : m0_wstrb);
                    else begin
                        expect_ev(1, int'(p), p ? m1_addr : m0_addr, '0, '0);
                        m_idle  = 1'b0;
                        m_owner = p;
                    end
                end
            end else begin
                expect_ev(2, int'(m_owner), '0, io_rdata, '0);
                m_idle = 1'b1;
            end
        end
        nxt();
        set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        if (!m_idle) expect_ev(2, int'(m_owner), '0, io_rdata, '0);
        repeat (3) nxt();

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
